// File: rtl/mul_pkg.sv
// -----------------------------------------------------------------------------
// mul_pkg
// Shared definitions for the sequential shift-and-add multiplier:
//   - controller state encoding (IDLE / RUN / DONE)
//   - clog2 helper used to size the iteration counter
// Optional build macro honoured by the users of this package: MUL_SIGNED_EN
// -----------------------------------------------------------------------------
package mul_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        STATE_IDLE = ST_IDLE,
        STATE_RUN  = ST_RUN,
        STATE_DONE = ST_DONE
    } state_t;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/mul_sa_ctrl.sv
// -----------------------------------------------------------------------------
// mul_sa_ctrl
// Controller FSM for the shift-and-add multiplier. Accepts start in IDLE or
// DONE, sequences the iterations and raises busy/done.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for start; product held
//   RUN   | one shift-and-add iteration per clock
//   DONE  | one-cycle done pulse; start here begins the next operation
//
// Ports:
//   clk, rst_n       clock, async active-low reset
//   start            operation request
//   operand_zero     an operand is zero (zero-skip candidate)
//   eqz, b_lsb,      status from the datapath
//   cnt_last
//   load, add_en,    datapath enables
//   shift_en, store_product, clr_product
//   busy, done       handshake toward the requester
// -----------------------------------------------------------------------------
module mul_sa_ctrl
    import mul_pkg::*;
#(
    parameter bit EARLY_TERM = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic operand_zero,
    input  logic eqz,
    input  logic b_lsb,
    input  logic cnt_last,
    output logic load,
    output logic add_en,
    output logic shift_en,
    output logic store_product,
    output logic clr_product,
    output logic busy,
    output logic done
);

    state_t state_r;
    state_t state_nxt;

    logic zero_skip;
    logic last_iter;

    assign zero_skip = EARLY_TERM && operand_zero;
    assign last_iter = cnt_last || (EARLY_TERM && eqz);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= STATE_IDLE;
        end else begin
            state_r <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state_r;
        load          = 1'b0;
        add_en        = 1'b0;
        shift_en      = 1'b0;
        store_product = 1'b0;
        clr_product   = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;

        case (state_r)
            STATE_IDLE: begin
                if (start) begin
                    load        = 1'b1;
                    clr_product = zero_skip;
                    state_nxt   = zero_skip ? STATE_DONE : STATE_RUN;
                end
            end

            STATE_RUN: begin
                busy     = 1'b1;
                shift_en = 1'b1;
                add_en   = b_lsb;
                if (last_iter) begin
                    store_product = 1'b1;
                    state_nxt     = STATE_DONE;
                end
            end

            STATE_DONE: begin
                done = 1'b1;
                if (start) begin
                    load        = 1'b1;
                    clr_product = zero_skip;
                    state_nxt   = zero_skip ? STATE_DONE : STATE_RUN;
                end else begin
                    state_nxt = STATE_IDLE;
                end
            end

            default: begin
                state_nxt = STATE_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/mul_sa_datapath.sv
// -----------------------------------------------------------------------------
// mul_sa_datapath
// Operand registers, accumulator, iteration counter, adder and the product
// register of the shift-and-add multiplier. Pure datapath: every update is
// gated by an enable from mul_sa_ctrl.
//
// Build macro: MUL_SIGNED_EN -- operands are two's complement; magnitudes are
// multiplied and the sign is reapplied when the product is stored.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   load              capture a_in/b_in, clear accumulator and counter
//   add_en            accumulate A_r into P_r this edge
//   shift_en          shift A_r left, B_r right, count one iteration
//   store_product     copy the final accumulator (incl. this edge's add)
//   clr_product       force product to zero (zero-skip)
//   a_in, b_in        operands
//   operand_zero      a_in or b_in is zero (combinational)
//   eqz               remaining multiplier bits above bit 0 are zero
//   b_lsb             current multiplier bit
//   cnt_last          this is iteration WIDTH-1
//   product           result register
// -----------------------------------------------------------------------------
module mul_sa_datapath
    import mul_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               add_en,
    input  logic               shift_en,
    input  logic               store_product,
    input  logic               clr_product,
    input  logic [WIDTH-1:0]   a_in,
    input  logic [WIDTH-1:0]   b_in,
    output logic               operand_zero,
    output logic               eqz,
    output logic               b_lsb,
    output logic               cnt_last,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [2*WIDTH-1:0] a_r;
    logic [WIDTH-1:0]   b_r;
    logic [2*WIDTH-1:0] p_r;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] product_r;

    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [2*WIDTH-1:0] p_sum;
    logic [2*WIDTH-1:0] product_nxt;

`ifdef MUL_SIGNED_EN
    logic neg_r;

    // Two's-complement negation of the most negative value wraps back to
    // itself, which read as unsigned is exactly its magnitude.
    assign a_mag = a_in[WIDTH-1] ? (~a_in + WIDTH'(1)) : a_in;
    assign b_mag = b_in[WIDTH-1] ? (~b_in + WIDTH'(1)) : b_in;
`else
    assign a_mag = a_in;
    assign b_mag = b_in;
`endif

    // A_r never exceeds 2^(2*WIDTH-1) and the partial sum never exceeds the
    // full product, so the 2*WIDTH-bit add cannot overflow.
    assign p_sum = p_r + (add_en ? a_r : '0);

`ifdef MUL_SIGNED_EN
    assign product_nxt = neg_r ? (~p_sum + (2*WIDTH)'(1)) : p_sum;
`else
    assign product_nxt = p_sum;
`endif

    assign operand_zero = (a_in == '0) || (b_in == '0);
    assign eqz          = (b_r[WIDTH-1:1] == '0);
    assign b_lsb        = b_r[0];
    assign cnt_last     = (cnt == CNT_LAST);
    assign product      = product_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r <= '0;
            b_r <= '0;
            p_r <= '0;
            cnt <= '0;
        end else if (load) begin
            a_r <= {{WIDTH{1'b0}}, a_mag};
            b_r <= b_mag;
            p_r <= '0;
            cnt <= '0;
        end else if (shift_en) begin
            a_r <= a_r << 1;
            b_r <= b_r >> 1;
            p_r <= p_sum;
            cnt <= cnt + CW'(1);
        end
    end

`ifdef MUL_SIGNED_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_r <= 1'b0;
        end else if (load) begin
            neg_r <= a_in[WIDTH-1] ^ b_in[WIDTH-1];
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            product_r <= '0;
        end else if (clr_product) begin
            product_r <= '0;
        end else if (store_product) begin
            product_r <= product_nxt;
        end
    end

endmodule

// File: rtl/mul_seq_shift_add.sv
// -----------------------------------------------------------------------------
// mul_seq_shift_add
// Sequential WIDTH x WIDTH -> 2*WIDTH multiplier using iterative shift-and-add,
// with optional early termination once the remaining multiplier bits are zero.
//
// Build macro: MUL_SIGNED_EN -- treat operands as two's complement.
//
// Parameters:
//   WIDTH       operand width (2..64)
//   EARLY_TERM  1: stop when remaining multiplier bits are zero; 0: WIDTH steps
//
// Ports:
//   clk      system clock, rising edge
//   rst_n    asynchronous active-low reset
//   start    request, sampled in IDLE or DONE
//   a_in     multiplicand, captured on the accepting edge
//   b_in     multiplier, captured on the accepting edge
//   busy     high while iterating
//   done     one-cycle completion pulse
//   product  result, held until the next completion
// -----------------------------------------------------------------------------
module mul_seq_shift_add
    import mul_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter bit EARLY_TERM = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a_in,
    input  logic [WIDTH-1:0]   b_in,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    logic load;
    logic add_en;
    logic shift_en;
    logic store_product;
    logic clr_product;
    logic operand_zero;
    logic eqz;
    logic b_lsb;
    logic cnt_last;

    mul_sa_ctrl #(
        .EARLY_TERM (EARLY_TERM)
    ) u_ctrl (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .operand_zero  (operand_zero),
        .eqz           (eqz),
        .b_lsb         (b_lsb),
        .cnt_last      (cnt_last),
        .load          (load),
        .add_en        (add_en),
        .shift_en      (shift_en),
        .store_product (store_product),
        .clr_product   (clr_product),
        .busy          (busy),
        .done          (done)
    );

    mul_sa_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk           (clk),
        .rst_n         (rst_n),
        .load          (load),
        .add_en        (add_en),
        .shift_en      (shift_en),
        .store_product (store_product),
        .clr_product   (clr_product),
        .a_in          (a_in),
        .b_in          (b_in),
        .operand_zero  (operand_zero),
        .eqz           (eqz),
        .b_lsb         (b_lsb),
        .cnt_last      (cnt_last),
        .product       (product)
    );

endmodule

// File: tb/tb_mul_seq_shift_add.sv
// Two instances: index 0 runs fixed WIDTH iterations, index 1 terminates early.
module tb_mul_seq_shift_add;

    localparam int W = 16;

    logic          clk;
    logic          rst_n;
    logic          start_v [2];
    logic [W-1:0]  a_v     [2];
    logic [W-1:0]  b_v     [2];
    logic          busy_v  [2];
    logic          done_v  [2];
    logic [2*W-1:0] prod_v [2];

    int checks;
    int failures;

    mul_seq_shift_add #(.WIDTH(W), .EARLY_TERM(1'b0)) u_dut_fix (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .a_in(a_v[0]), .b_in(b_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .product(prod_v[0])
    );

    mul_seq_shift_add #(.WIDTH(W), .EARLY_TERM(1'b1)) u_dut_et (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .a_in(a_v[1]), .b_in(b_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .product(prod_v[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the arithmetic product of the operands as the design reads them.
    function automatic logic [2*W-1:0] exp_prod(input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb;
`ifdef MUL_SIGNED_EN
        sa = longint'($signed(a));
        sb = longint'($signed(b));
`else
        sa = longint'(a);
        sb = longint'(b);
`endif
        return (2*W)'(sa * sb);
    endfunction

    // Reference: number of iterations before done.
    function automatic int exp_lat(input int sel, input logic [W-1:0] a, input logic [W-1:0] b);
        longint mag;
        int k;
        if (sel == 0) return W;
        if (a == '0 || b == '0) return 0;
`ifdef MUL_SIGNED_EN
        mag = longint'($signed(b));
        if (mag < 0) mag = -mag;
`else
        mag = longint'(b);
`endif
        k = 0;
        for (int i = 0; i <= W; i++) if (mag[i]) k = i + 1;
        return k;
    endfunction

    // Issue one request and return at the negedge where done is first seen.
    task automatic run_op(input int sel, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat, output int busy_cycles);
        @(negedge clk);
        start_v[sel] = 1'b1; a_v[sel] = a; b_v[sel] = b;
        @(negedge clk);
        start_v[sel] = 1'b0; a_v[sel] = W'($urandom); b_v[sel] = W'($urandom);
        lat = -1; busy_cycles = 0;
        for (int i = 0; i < 200; i++) begin
            if (done_v[sel]) begin
                lat = i;
                break;
            end
            if (busy_v[sel]) busy_cycles++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int s = 0; s < 2; s++) begin
            start_v[s] = 1'b0; a_v[s] = '0; b_v[s] = '0;
        end
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            checks++;
            if (busy_v[s] !== 1'b0 || done_v[s] !== 1'b0 || prod_v[s] !== '0) begin
                failures++;
                $display("FAIL reset_state dut=%0d busy=%b done=%b product=%h required 0/0/0", s, busy_v[s], done_v[s], prod_v[s]);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        int lat, bc;
        run_op(1, 16'd4, 16'd3, lat, bc);
        checks++;
        if (prod_v[1] !== exp_prod(16'd4, 16'd3) || lat != 2 || bc != 2) begin
            failures++;
            $display("FAIL dir_4x3 product=%h lat=%0d busy=%0d required %h/2/2", prod_v[1], lat, bc, exp_prod(16'd4, 16'd3));
        end
        @(negedge clk);
        checks++;
        if (done_v[1] !== 1'b0 || prod_v[1] !== exp_prod(16'd4, 16'd3)) begin
            failures++;
            $display("FAIL dir_done_pulse done=%b product=%h required 0/%h", done_v[1], prod_v[1], exp_prod(16'd4, 16'd3));
        end
        run_op(1, 16'd1234, 16'd0, lat, bc);
        checks++;
        if (prod_v[1] !== '0 || lat != 0) begin
            failures++;
            $display("FAIL dir_zero_b product=%h lat=%0d required 0/0", prod_v[1], lat);
        end
        run_op(1, 16'd0, 16'h8000, lat, bc);
        checks++;
        if (prod_v[1] !== '0 || lat != 0 || bc != 0) begin
            failures++;
            $display("FAIL dir_zero_a product=%h lat=%0d busy=%0d required 0/0/0", prod_v[1], lat, bc);
        end
        run_op(0, 16'd1234, 16'd0, lat, bc);
        checks++;
        if (prod_v[0] !== '0 || lat != W) begin
            failures++;
            $display("FAIL dir_fixed_zero product=%h lat=%0d required 0/%0d", prod_v[0], lat, W);
        end
    endtask

    task automatic test_ignore_start();
        int lat, extra_done;
        logic [2*W-1:0] exp;
        exp = exp_prod(16'hFFFF, 16'hFFFF);
        @(negedge clk);
        start_v[0] = 1'b1; a_v[0] = 16'hFFFF; b_v[0] = 16'hFFFF;
        @(negedge clk);
        lat = -1;
        for (int i = 0; i < 60; i++) begin
            start_v[0] = (i <= 14) ? 1'(i % 2) : 1'b0;
            a_v[0] = W'($urandom); b_v[0] = W'($urandom);
            if (done_v[0]) begin
                lat = i;
                break;
            end
            @(negedge clk);
        end
        start_v[0] = 1'b0;
        checks++;
        if (lat != W || prod_v[0] !== exp) begin
            failures++;
            $display("FAIL ffff_sq lat=%0d product=%h required %0d/%h", lat, prod_v[0], W, exp);
        end
        extra_done = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (done_v[0] || busy_v[0] || prod_v[0] !== exp) extra_done++;
        end
        checks++;
        if (extra_done != 0) begin
            failures++;
            $display("FAIL ignore_start bad_cycles=%0d required 0", extra_done);
        end
    endtask

    task automatic test_back_to_back(input int sel);
        int lat1, lat2, gap_busy;
        logic [2*W-1:0] p1;
        @(negedge clk);
        start_v[sel] = 1'b1; a_v[sel] = 16'd7; b_v[sel] = 16'd9;
        @(negedge clk);
        a_v[sel] = 16'd5; b_v[sel] = 16'd6;
        lat1 = -1;
        for (int i = 0; i < 100; i++) begin
            if (done_v[sel]) begin lat1 = i; break; end
            @(negedge clk);
        end
        p1 = prod_v[sel];
        @(negedge clk);
        start_v[sel] = 1'b0; a_v[sel] = W'($urandom); b_v[sel] = W'($urandom);
        gap_busy = int'(busy_v[sel]);
        lat2 = -1;
        for (int i = 0; i < 100; i++) begin
            if (done_v[sel]) begin lat2 = i; break; end
            @(negedge clk);
        end
        checks++;
        if (p1 !== exp_prod(16'd7, 16'd9) || lat1 != exp_lat(sel, 16'd7, 16'd9)) begin
            failures++;
            $display("FAIL b2b_first dut=%0d product=%h lat=%0d required %h/%0d", sel, p1, lat1, exp_prod(16'd7, 16'd9), exp_lat(sel, 16'd7, 16'd9));
        end
        checks++;
        if (gap_busy != 1 || prod_v[sel] !== exp_prod(16'd5, 16'd6) || lat2 != exp_lat(sel, 16'd5, 16'd6)) begin
            failures++;
            $display("FAIL b2b_second dut=%0d busy_after_done=%0d product=%h lat=%0d required 1/%h/%0d", sel, gap_busy, prod_v[sel], lat2, exp_prod(16'd5, 16'd6), exp_lat(sel, 16'd5, 16'd6));
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        int bad, lat, bc;
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            start_v[s] = 1'b1; a_v[s] = 16'd100; b_v[s] = 16'd200;
        end
        @(negedge clk);
        for (int s = 0; s < 2; s++) start_v[s] = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        for (int s = 0; s < 2; s++) begin
            checks++;
            if (busy_v[s] !== 1'b0 || done_v[s] !== 1'b0 || prod_v[s] !== '0) begin
                failures++;
                $display("FAIL async_reset dut=%0d busy=%b done=%b product=%h required 0/0/0", s, busy_v[s], done_v[s], prod_v[s]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (done_v[0] || done_v[1] || busy_v[0] || busy_v[1]) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL abort_no_done bad_cycles=%0d required 0", bad);
        end
        for (int s = 0; s < 2; s++) begin
            run_op(s, 16'd2, 16'd3, lat, bc);
            checks++;
            if (prod_v[s] !== exp_prod(16'd2, 16'd3) || lat != exp_lat(s, 16'd2, 16'd3)) begin
                failures++;
                $display("FAIL after_reset dut=%0d product=%h lat=%0d required %h/%0d", s, prod_v[s], lat, exp_prod(16'd2, 16'd3), exp_lat(s, 16'd2, 16'd3));
            end
        end
    endtask

    task automatic test_random(input int sel, input int n);
        int lat, bc;
        logic [W-1:0] a, b;
        for (int t = 0; t < n; t++) begin
            a = W'($urandom);
            b = W'($urandom);
            case ($urandom_range(0, 4))
                0: b = b >> $urandom_range(0, W - 1);
                1: a = '0;
                2: b = (t % 2 == 0) ? '0 : 16'h8000;
                3: a = (t % 2 == 0) ? 16'h8000 : 16'hFFFF;
                default: ;
            endcase
            run_op(sel, a, b, lat, bc);
            checks++;
            if (prod_v[sel] !== exp_prod(a, b) || lat != exp_lat(sel, a, b) || bc != exp_lat(sel, a, b)) begin
                failures++;
                $display("FAIL random dut=%0d a=%h b=%h product=%h lat=%0d busy=%0d required %h/%0d", sel, a, b, prod_v[sel], lat, bc, exp_prod(a, b), exp_lat(sel, a, b));
            end
            @(negedge clk);
            checks++;
            if (done_v[sel] !== 1'b0 || prod_v[sel] !== exp_prod(a, b)) begin
                failures++;
                $display("FAIL random_hold dut=%0d done=%b product=%h required 0/%h", sel, done_v[sel], prod_v[sel], exp_prod(a, b));
            end
        end
    endtask

`ifdef MUL_SIGNED_EN
    task automatic test_signed();
        int lat, bc;
        run_op(1, 16'hFFFD, 16'd5, lat, bc);
        checks++;
        if (prod_v[1] !== 32'hFFFFFFF1) begin
            failures++;
            $display("FAIL signed_m3x5 product=%h required FFFFFFF1", prod_v[1]);
        end
        run_op(1, 16'h8000, 16'h8000, lat, bc);
        checks++;
        if (prod_v[1] !== 32'h40000000) begin
            failures++;
            $display("FAIL signed_min_sq product=%h required 40000000", prod_v[1]);
        end
        run_op(0, 16'hFFFF, 16'hFFFF, lat, bc);
        checks++;
        if (prod_v[0] !== 32'h00000001) begin
            failures++;
            $display("FAIL signed_m1_sq product=%h required 00000001", prod_v[0]);
        end
    endtask
`endif

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_directed();
        test_ignore_start();
        test_back_to_back(1);
        test_back_to_back(0);
        test_reset_mid_run();
`ifdef MUL_SIGNED_EN
        test_signed();
`endif
        test_random(1, 60);
        test_random(0, 30);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
